// File: rtl/cpu_multiciclo_param.sv
// Parametrised multi-cycle CPU core: FE/DE/EX/MA/WB sequencer, 8-entry register
// file with hard-wired r0, inline ALU with {N,Z,C,O} flags, ready-handshaked memory.
module cpu_multiciclo_param #(
    parameter int          BITS_DATA = 32,
    parameter int          BITS_ADDR = 16,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITS_DATA-1:0] MBR_R,
    input  logic                 ready,
    output logic [BITS_DATA-1:0] MBR_W,
    output logic [BITS_ADDR-1:0] MAR,
    output logic                 write,
    output logic                 halted,
    output logic                 illegal,
    output logic [3:0]           flags
);
    localparam int D = BITS_DATA;

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_ADDI = 5'd8;
    localparam logic [4:0] OP_LD   = 5'd9;
    localparam logic [4:0] OP_ST   = 5'd10;
    localparam logic [4:0] OP_BEQ  = 5'd11;
    localparam logic [4:0] OP_JMP  = 5'd12;
    localparam logic [4:0] OP_HLT  = 5'd13;

    typedef enum logic [2:0] {
        S_FE_0, S_FE_1, S_DE, S_EX, S_MA_0, S_MA_1, S_WB, S_HLT
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [BITS_ADDR-1:0] r_pc;
    logic [BITS_ADDR-1:0] r_mar;
    logic [BITS_ADDR-1:0] r_ea;
    logic [D-1:0]         r_ir;
    logic [D-1:0]         r_a;
    logic [D-1:0]         r_b;
    logic [D-1:0]         r_result;
    logic [D-1:0]         r_mbr_w;
    logic [3:0]           r_flags;
    logic                 r_write;
    logic                 r_halted;
    logic                 r_illegal;
    logic [D-1:0]         r_gpr [1:7];

    logic [4:0]           w_op;
    logic [2:0]           w_rd;
    logic [2:0]           w_rs;
    logic [2:0]           w_rt;
    logic [BITS_ADDR-1:0] w_imm;
    logic [D-1:0]         w_sext;
    logic [D-1:0]         w_rs_val;
    logic [D-1:0]         w_rt_val;
    logic [D-1:0]         w_rd_val;
    logic [D-1:0]         w_opnd_b;
    logic [D:0]           w_sum;
    logic [D-1:0]         w_alu_res;
    logic                 w_alu_c;
    logic                 w_alu_o;
    logic                 w_is_alu;
    logic                 w_is_mem;
    logic                 w_is_illegal;

    assign w_op   = r_ir[D-1 -: 5];
    assign w_rd   = r_ir[D-6 -: 3];
    assign w_rs   = r_ir[D-9 -: 3];
    assign w_rt   = r_ir[D-12 -: 3];
    assign w_imm  = r_ir[BITS_ADDR-1:0];
    assign w_sext = {{(D-BITS_ADDR){w_imm[BITS_ADDR-1]}}, w_imm};

    assign w_is_alu     = (w_op >= OP_ADD) && (w_op <= OP_ADDI);
    assign w_is_mem     = (w_op == OP_LD) || (w_op == OP_ST);
    assign w_is_illegal = (w_op > OP_HLT);

    generate
        if (D > BITS_ADDR + 14) begin : g_spare_ir
            logic w_unused_ir;
            assign w_unused_ir = ^r_ir[D-15:BITS_ADDR];
        end
    endgenerate

    // r0 is not stored: every read port defaults to zero and only r1..r7 can match.
    always_comb begin
        w_rs_val = '0;
        w_rt_val = '0;
        w_rd_val = '0;
        for (int i = 1; i < 8; i++) begin
            if (w_rs == 3'(i)) w_rs_val = r_gpr[i];
            if (w_rt == 3'(i)) w_rt_val = r_gpr[i];
            if (w_rd == 3'(i)) w_rd_val = r_gpr[i];
        end
    end

    // Carry/borrow falls out of the extra top bit of the widened sum.
    always_comb begin
        w_opnd_b  = (w_op == OP_ADDI) ? w_sext : r_b;
        w_sum     = '0;
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_o   = 1'b0;
        case (w_op)
            OP_ADD, OP_ADDI: begin
                w_sum     = {1'b0, r_a} + {1'b0, w_opnd_b};
                w_alu_res = w_sum[D-1:0];
                w_alu_c   = w_sum[D];
                w_alu_o   = (r_a[D-1] == w_opnd_b[D-1]) && (w_alu_res[D-1] != r_a[D-1]);
            end
            OP_SUB: begin
                w_sum     = {1'b0, r_a} - {1'b0, r_b};
                w_alu_res = w_sum[D-1:0];
                w_alu_c   = w_sum[D];
                w_alu_o   = (r_a[D-1] != r_b[D-1]) && (w_alu_res[D-1] != r_a[D-1]);
            end
            OP_AND: w_alu_res = r_a & r_b;
            OP_OR:  w_alu_res = r_a | r_b;
            OP_XOR: w_alu_res = r_a ^ r_b;
            OP_SHL: w_alu_res = r_a << r_b[4:0];
            OP_SHR: w_alu_res = r_a >> r_b[4:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FE_0;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FE_0: w_state_next = S_FE_1;
            S_FE_1: if (ready) w_state_next = S_DE;
            S_DE:   w_state_next = S_EX;
            S_EX: begin
                if (w_is_alu)                            w_state_next = S_WB;
                else if (w_is_mem)                       w_state_next = S_MA_0;
                else if (w_op == OP_HLT || w_is_illegal) w_state_next = S_HLT;
                else                                     w_state_next = S_FE_0;
            end
            S_MA_0: w_state_next = S_MA_1;
            S_MA_1: if (ready) w_state_next = (w_op == OP_LD) ? S_WB : S_FE_0;
            S_WB:   w_state_next = S_FE_0;
            S_HLT:  w_state_next = S_HLT;
            default: w_state_next = S_FE_0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= BITS_ADDR'(RESET_PC);
            r_mar     <= '0;
            r_ea      <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_mbr_w   <= '0;
            r_flags   <= '0;
            r_write   <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 1; i < 8; i++) r_gpr[i] <= '0;
        end else begin
            case (r_state)
                S_FE_0: begin
                    r_mar   <= r_pc;
                    r_write <= 1'b0;
                end
                S_FE_1: if (ready) begin
                    r_ir <= MBR_R;
                    r_pc <= r_pc + 1'b1;
                end
                S_DE: begin
                    r_a <= w_rs_val;
                    r_b <= (w_op == OP_ST || w_op == OP_BEQ) ? w_rd_val : w_rt_val;
                end
                S_EX: begin
                    if (w_is_alu) begin
                        r_result <= w_alu_res;
                        r_flags  <= {w_alu_res[D-1], (w_alu_res == '0), w_alu_c, w_alu_o};
                    end
                    if (w_is_mem) r_ea <= r_a[BITS_ADDR-1:0] + w_imm;
                    if ((w_op == OP_BEQ && r_b == r_a) || w_op == OP_JMP) r_pc <= w_imm;
                    if (w_op == OP_HLT || w_is_illegal) r_halted <= 1'b1;
                    if (w_is_illegal) r_illegal <= 1'b1;
                end
                S_MA_0: begin
                    r_mar <= r_ea;
                    if (w_op == OP_ST) begin
                        r_mbr_w <= w_rd_val;
                        r_write <= 1'b1;
                    end
                end
                S_MA_1: if (ready) begin
                    r_write <= 1'b0;
                    if (w_op == OP_LD) r_result <= MBR_R;
                end
                S_WB: if (w_rd != 3'd0) r_gpr[w_rd] <= r_result;
                default: ;
            endcase
        end
    end

    assign MBR_W   = r_mbr_w;
    assign MAR     = r_mar;
    assign write   = r_write;
    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign flags   = r_flags;
endmodule

// File: tb/tb_cpu_multiciclo_param.sv
// Bench for cpu_multiciclo_param: an ISA-level interpreter predicts every store and the
// final status; a monitor pops the expected stores as the core's writes are accepted.
module tb_cpu_multiciclo_param;
    localparam int D = 32;
    localparam int A = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ready = 1'b1;
    logic [D-1:0]  MBR_R;
    logic [D-1:0]  MBR_W;
    logic [A-1:0]  MAR;
    logic          write;
    logic          halted;
    logic          illegal;
    logic [3:0]    flags;

    always #5 clk = ~clk;

    cpu_multiciclo_param #(.BITS_DATA(D), .BITS_ADDR(A), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .MBR_R(MBR_R), .ready(ready), .MBR_W(MBR_W),
        .MAR(MAR), .write(write), .halted(halted), .illegal(illegal), .flags(flags)
    );

    logic [D-1:0] mem  [0:65535];
    logic [D-1:0] rmem [0:65535];
    assign MBR_R = mem[MAR];

    typedef struct {
        logic [A-1:0] addr;
        logic [D-1:0] data;
        logic [3:0]   fl;
    } st_t;
    st_t sb[$];

    int total = 0;
    int bad   = 0;
    int rmode = 0;   // 0: ready high, 1: random, 2: two wait cycles per write, 3: ready=!write
    int wcnt  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end else begin
            $display("ok   %s = %h", nm, got);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt,
                                        input logic [15:0] imm);
        logic [4:0] o;
        logic [2:0] d, s, t;
        o = op[4:0]; d = rd[2:0]; s = rs[2:0]; t = rt[2:0];
        return {o, d, s, t, 2'b00, imm};
    endfunction

    // Ready generator, updated away from the active edge.
    initial begin
        int hold;
        hold = 0;
        forever begin
            @(negedge clk);
            case (rmode)
                1: ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (write && hold < 2) begin
                        ready = 1'b0;
                        hold++;
                    end else begin
                        ready = 1'b1;
                        if (!write) hold = 0;
                    end
                end
                3: ready = !write;
                default: ready = 1'b1;
            endcase
        end
    end

    // Monitor: an accepted write is the observable store transaction; it also commits memory.
    initial begin
        st_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && write) wcnt++;
            if (!reset && write && ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL store_unexpected addr=%h data=%h", MAR, MBR_W);
                end else begin
                    e = sb.pop_front();
                    if (MAR !== e.addr || MBR_W !== e.data || flags !== e.fl) begin
                        bad++;
                        $display("FAIL store got addr=%h data=%h flags=%b want addr=%h data=%h flags=%b",
                                 MAR, MBR_W, flags, e.addr, e.data, e.fl);
                    end else begin
                        $display("store ok addr=%h data=%h flags=%b", MAR, MBR_W, flags);
                    end
                end
                mem[MAR] = MBR_W;
            end
        end
    end

    // Instruction-level interpreter: executes the program image and pushes expected stores.
    task automatic model(output int cyc, output bit ill, output logic [3:0] fl,
                         output logic [15:0] lastpc);
        logic [31:0] r [8];
        logic [31:0] ir, a, b, d, bi, res;
        logic [15:0] pc, imm, ea;
        int op, rd, rs, rt;
        longint ua, ub, sa, sb2, s;
        bit c, o, fin;
        st_t e;
        for (int i = 0; i < 8; i++) r[i] = '0;
        for (int i = 0; i < 65536; i++) rmem[i] = mem[i];
        pc = '0; cyc = 0; ill = 0; fl = '0; lastpc = '0; fin = 0;
        for (int n = 0; n < 20000 && !fin; n++) begin
            ir = rmem[pc]; lastpc = pc;
            op = int'(ir[31:27]); rd = int'(ir[26:24]); rs = int'(ir[23:21]); rt = int'(ir[20:18]);
            imm = ir[15:0];
            a = r[rs]; b = r[rt]; d = r[rd];
            pc = pc + 16'd1;
            c = 0; o = 0; res = '0;
            if (op >= 1 && op <= 8) begin
                bi = (op == 8) ? {{16{imm[15]}}, imm} : b;
                ua = a; ub = bi;
                sa = longint'($signed(a)); sb2 = longint'($signed(bi));
                case (op)
                    1, 8: begin
                        res = a + bi;
                        c = ((ua + ub) >> 32) != 0;
                        s = sa + sb2;
                        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                    end
                    2: begin
                        res = a - bi;
                        c = ua < ub;
                        s = sa - sb2;
                        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                    end
                    3: res = a & b;
                    4: res = a | b;
                    5: res = a ^ b;
                    6: res = a << b[4:0];
                    default: res = a >> b[4:0];
                endcase
                fl = {res[31], (res == 32'd0), c, o};
                if (rd != 0) r[rd] = res;
                cyc += 5;
            end else begin
                case (op)
                    0: cyc += 4;
                    9: begin
                        ea = a[15:0] + imm;
                        if (rd != 0) r[rd] = rmem[ea];
                        cyc += 7;
                    end
                    10: begin
                        ea = a[15:0] + imm;
                        e.addr = ea; e.data = d; e.fl = fl;
                        sb.push_back(e);
                        rmem[ea] = d;
                        cyc += 6;
                    end
                    11: begin
                        if (d == a) pc = imm;
                        cyc += 4;
                    end
                    12: begin
                        pc = imm;
                        cyc += 4;
                    end
                    13: begin
                        cyc += 4;
                        fin = 1;
                    end
                    default: begin
                        cyc += 4;
                        fin = 1;
                        ill = 1;
                    end
                endcase
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = '0;
    endtask

    task automatic wait_halt(input string nm, input int m_cyc, input bit m_ill, input logic [3:0] m_fl,
                             input logic [15:0] m_pc, input bit chk_cyc, input int extra);
        int cnt;
        bit done;
        cnt = 0; done = 0;
        while (!done && cnt < 20000) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            #2;
            if (halted) done = 1;
        end
        chk({nm, "_halt_reached"}, 32'(done), 32'd1);
        chk({nm, "_illegal"}, 32'(illegal), 32'(m_ill));
        chk({nm, "_flags"}, 32'(flags), 32'(m_fl));
        chk({nm, "_halt_mar"}, 32'(MAR), 32'(m_pc));
        chk({nm, "_stores_left"}, 32'(sb.size()), 32'd0);
        if (chk_cyc) chk({nm, "_cycles"}, 32'(cnt), 32'(m_cyc + extra));
        repeat (4) @(negedge clk);
        #2;
        chk({nm, "_stays_halted"}, {MAR, 13'd0, write, halted, illegal}, {m_pc, 13'd0, 1'b0, 1'b1, m_ill});
    endtask

    task automatic run_prog(input string nm, input int rm, input bit chk_cyc, input int extra);
        int m_cyc;
        bit m_ill;
        logic [3:0] m_fl;
        logic [15:0] m_pc;
        reset = 1'b1;
        rmode = rm;
        sb.delete();
        model(m_cyc, m_ill, m_fl, m_pc);
        repeat (2) @(negedge clk);
        #2;
        chk({nm, "_rst_status"}, {25'd0, write, halted, illegal, flags}, 32'd0);
        chk({nm, "_rst_mar"}, 32'(MAR), 32'd0);
        chk({nm, "_rst_mbrw"}, MBR_W, 32'd0);
        wcnt = 0;
        reset = 1'b0;
        wait_halt(nm, m_cyc, m_ill, m_fl, m_pc, chk_cyc, extra);
    endtask

    task automatic gen_random(input int body);
        int k, rd, rs, rt, tgt, last;
        logic [15:0] imm;
        clear_mem();
        for (int i = 0; i < 8; i++) mem[16'h9000 + i] = $urandom();
        for (int i = 1; i < 8; i++) mem[i-1] = enc(8, i, 0, 0, 16'($urandom()));
        last = 7 + body;
        for (int p = 7; p < last; p++) begin
            k = $urandom_range(0, 15);
            rd = $urandom_range(0, 7); rs = $urandom_range(0, 7); rt = $urandom_range(0, 7);
            imm = 16'($urandom());
            tgt = p + 1 + $urandom_range(0, 2);
            if (tgt > last) tgt = last;
            case (k)
                0: mem[p] = enc(0, 0, 0, 0, 16'd0);
                1, 2, 3, 4, 5, 6, 7, 8: mem[p] = enc(k, rd, rs, rt, imm);
                9, 10: mem[p] = enc(8, rd, rs, 0, imm);
                11: mem[p] = enc(9, rd, 0, 0, 16'(16'h9000 + $urandom_range(0, 7)));
                12: mem[p] = enc(10, rd, 0, 0, 16'(16'h9000 + $urandom_range(0, 7)));
                13: mem[p] = enc(11, rd, rs, 0, 16'(tgt));
                14: mem[p] = enc(12, 0, 0, 0, 16'(tgt));
                default: mem[p] = enc(1, rd, rs, rt, imm);
            endcase
        end
        for (int r = 1; r < 8; r++) mem[last + r - 1] = enc(10, r, 0, 0, 16'(16'h8000 + r));
        mem[last + 7] = enc(13, 0, 0, 0, 16'd0);
    endtask

    initial begin
        int cnt;
        bit found;
        int m_cyc;
        bit m_ill;
        logic [3:0] m_fl;
        logic [15:0] m_pc;

        // Signed add with carry out; halts at cycle 19.
        clear_mem();
        mem[0] = enc(8, 1, 0, 0, 16'd5);
        mem[1] = enc(8, 2, 0, 0, 16'hFFFD);
        mem[2] = enc(1, 3, 1, 2, 16'd0);
        mem[3] = enc(13, 0, 0, 0, 16'd0);
        run_prog("addi_add", 0, 1, 0);

        // 0x80000000 + 0x80000000: zero result with carry and overflow.
        clear_mem();
        mem[0] = enc(8, 1, 0, 0, 16'd1);
        mem[1] = enc(8, 2, 0, 0, 16'd31);
        mem[2] = enc(6, 1, 1, 2, 16'd0);
        mem[3] = enc(1, 1, 1, 1, 16'd0);
        mem[4] = enc(10, 1, 0, 0, 16'h8000);
        mem[5] = enc(13, 0, 0, 0, 16'd0);
        run_prog("overflow", 0, 1, 0);

        // Store/load round trip with two wait cycles on each write.
        clear_mem();
        mem[0] = enc(8, 1, 0, 0, 16'h0040);
        mem[1] = enc(10, 1, 0, 0, 16'h0020);
        mem[2] = enc(9, 4, 0, 0, 16'h0020);
        mem[3] = enc(10, 4, 0, 0, 16'h0021);
        mem[4] = enc(13, 0, 0, 0, 16'd0);
        run_prog("st_ld_wait", 2, 1, 4);
        chk("st_ld_wait_write_cycles", 32'(wcnt), 32'd6);

        // Branches: wrap past 0xFFFF, taken BEQ, not-taken BEQ.
        clear_mem();
        mem[16'h0000] = enc(11, 1, 0, 0, 16'hFFFE);
        mem[16'hFFFE] = enc(8, 1, 0, 0, 16'd3);
        mem[16'hFFFF] = enc(10, 1, 0, 0, 16'h8002);
        mem[16'h0001] = enc(8, 2, 0, 0, 16'd3);
        mem[16'h0002] = enc(11, 1, 2, 0, 16'h0010);
        mem[16'h0003] = enc(10, 1, 0, 0, 16'h8001);
        mem[16'h0010] = enc(8, 2, 0, 0, 16'd4);
        mem[16'h0011] = enc(11, 1, 2, 0, 16'h0020);
        mem[16'h0012] = enc(10, 2, 0, 0, 16'h8000);
        mem[16'h0013] = enc(13, 0, 0, 0, 16'd0);
        mem[16'h0020] = enc(10, 1, 0, 0, 16'h8003);
        mem[16'h0021] = enc(13, 0, 0, 0, 16'd0);
        run_prog("branch", 0, 1, 0);

        // Write to r0 discarded; undefined opcode at address 3 stops the core.
        clear_mem();
        mem[0] = enc(8, 0, 0, 0, 16'd7);
        mem[1] = enc(1, 2, 0, 0, 16'd0);
        mem[2] = enc(10, 2, 0, 0, 16'h8000);
        mem[3] = 32'hF800_0000;
        run_prog("illegal", 0, 1, 0);

        // Reset while a store is waiting in its memory-access cycle.
        clear_mem();
        mem[0] = enc(8, 1, 0, 0, 16'h0040);
        mem[1] = enc(10, 1, 0, 0, 16'h0020);
        mem[2] = enc(13, 0, 0, 0, 16'd0);
        mem[16'h0020] = 32'hDEAD_BEEF;
        sb.delete();
        rmode = 3;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        found = 0;
        for (cnt = 0; cnt < 50 && !found; cnt++) begin
            @(negedge clk);
            #2;
            if (write) found = 1;
        end
        chk("rst_mid_st_write_seen", 32'(found), 32'd1);
        @(negedge clk);
        #2;
        chk("rst_mid_st_held", {write, 15'd0, MAR}, {1'b1, 15'd0, 16'h0020});
        chk("rst_mid_st_mbrw", MBR_W, 32'h40);
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_mid_st_after", {MAR, 11'd0, write, flags}, 32'd0);
        chk("rst_mid_st_mem", mem[16'h0020], 32'hDEAD_BEEF);
        rmode = 0;
        model(m_cyc, m_ill, m_fl, m_pc);
        @(negedge clk);
        #2;
        reset = 1'b0;
        wait_halt("rst_restart", m_cyc, m_ill, m_fl, m_pc, 1, 0);

        // Random programs, alternating ideal and randomly wait-stated memory.
        for (int t = 0; t < 8; t++) begin
            gen_random($urandom_range(12, 24));
            run_prog($sformatf("rand%0d", t), t % 2, (t % 2) == 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
